// File: rtl/shape_renderer.sv
// shape_renderer
// ----------------
// Renders a falling piece made of NUM_CELLS square cells onto a raster
// display. A new piece is loaded into a pending buffer and becomes the
// visible (front) piece only at the next frame_start, so the picture never
// tears mid-frame. Per-pixel hit/edge flags come out two cycles after the
// pixel coordinates go in.
//
// Ports
//   Clk, Reset_n              clock, asynchronous active-low reset
//   load_valid / load_ready   piece offer / acceptance handshake
//   load_x, load_y            cell coordinates, cell i at [i*W +: W]
//   load_color                colour index of the offered piece
//   clear                     remove both pending and front pieces
//   frame_start               one-cycle pulse at the start of each frame
//   blink_en                  blink the front piece every BLINK_FRAMES frames
//   DrawX, DrawY, pix_valid   current pixel and its qualifier
//   is_shape, is_edge         pixel inside / on border of a visible cell
//   shape_color               front colour, 0 when no front piece
//   state_dbg                 current FSM state (IDLE=0, PENDING=1,
//                             ACTIVE=2, ACTIVE_PEND=3)
//
// Handshake: a piece transfers on every rising Clk edge where load_valid and
// load_ready are both high. load_ready depends only on the state and clear,
// never on load_valid, and the source holds its data stable while waiting.
module shape_renderer #(
    parameter int CELL_PX      = 24,
    parameter int X_OFFSET     = 144,
    parameter int Y_OFFSET     = 0,
    parameter int NUM_CELLS    = 4,
    parameter int XW           = 4,
    parameter int YW           = 5,
    parameter int COLOR_W      = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [NUM_CELLS*XW-1:0] load_x,
    input  logic [NUM_CELLS*YW-1:0] load_y,
    input  logic [COLOR_W-1:0]      load_color,
    input  logic                    clear,
    input  logic                    frame_start,
    input  logic                    blink_en,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic                    pix_valid,
    output logic                    is_shape,
    output logic                    is_edge,
    output logic [COLOR_W-1:0]      shape_color,
    output logic [1:0]              state_dbg
);

    // Comparison width: wide enough that (cx+1)*CELL_PX never overflows.
    localparam int CW = 16;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PENDING     = 2'd1,
        ACTIVE      = 2'd2,
        ACTIVE_PEND = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   accept, promote, front_valid;

    logic [NUM_CELLS*XW-1:0] pend_x, front_x;
    logic [NUM_CELLS*YW-1:0] pend_y, front_y;
    logic [COLOR_W-1:0]      pend_color, front_color;

    logic [BW-1:0] blink_cnt;
    logic          visible;

    logic [NUM_CELLS-1:0] hit_c, edge_c, hit_s1, edge_s1;
    logic                 pv_s1;

    // ---------------- control FSM ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        promote    = 1'b0;
        load_ready = ((state == IDLE) || (state == ACTIVE)) && !clear;
        accept     = load_valid && load_ready;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:        if (accept) state_nxt = PENDING;
                PENDING:     if (frame_start) begin
                                 state_nxt = ACTIVE;
                                 promote   = 1'b1;
                             end
                // A load arriving with frame_start lands in pending and waits
                // for the following frame_start.
                ACTIVE:      if (accept) state_nxt = ACTIVE_PEND;
                ACTIVE_PEND: if (frame_start) begin
                                 state_nxt = ACTIVE;
                                 promote   = 1'b1;
                             end
                default:     state_nxt = IDLE;
            endcase
        end
    end

    assign front_valid = (state == ACTIVE) || (state == ACTIVE_PEND);
    assign state_dbg   = state;
    assign shape_color = front_valid ? front_color : '0;

    // ---------------- piece buffers ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_x      <= '0;
            pend_y      <= '0;
            pend_color  <= '0;
            front_x     <= '0;
            front_y     <= '0;
            front_color <= '0;
        end else if (clear) begin
            pend_x      <= '0;
            pend_y      <= '0;
            pend_color  <= '0;
            front_x     <= '0;
            front_y     <= '0;
            front_color <= '0;
        end else begin
            if (promote) begin
                front_x     <= pend_x;
                front_y     <= pend_y;
                front_color <= pend_color;
            end
            if (accept) begin
                pend_x     <= load_x;
                pend_y     <= load_y;
                pend_color <= load_color;
            end
        end
    end

    // ---------------- blink timer ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                visible   <= ~visible;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ---------------- per-cell compare ----------------
    logic [CW-1:0] rx, ry, lo_x, hi_x, lo_y, hi_y;
    logic          in_x, in_y, hit_x, hit_y, edge_x, edge_y;

    always_comb begin
        // Left of / above the playfield is never a hit, so the subtraction
        // below is only meaningful when in_x / in_y hold.
        in_x   = CW'(DrawX) >= CW'(X_OFFSET);
        in_y   = CW'(DrawY) >= CW'(Y_OFFSET);
        rx     = CW'(DrawX) - CW'(X_OFFSET);
        ry     = CW'(DrawY) - CW'(Y_OFFSET);
        lo_x   = '0;
        hi_x   = '0;
        lo_y   = '0;
        hi_y   = '0;
        hit_x  = 1'b0;
        hit_y  = 1'b0;
        edge_x = 1'b0;
        edge_y = 1'b0;
        hit_c  = '0;
        edge_c = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            lo_x   = CW'(front_x[i*XW +: XW]) * CW'(CELL_PX);
            hi_x   = lo_x + CW'(CELL_PX - 1);
            lo_y   = CW'(front_y[i*YW +: YW]) * CW'(CELL_PX);
            hi_y   = lo_y + CW'(CELL_PX - 1);
            hit_x  = in_x && (rx >= lo_x) && (rx <= hi_x);
            hit_y  = in_y && (ry >= lo_y) && (ry <= hi_y);
            edge_x = (rx == lo_x) || (rx == hi_x);
            edge_y = (ry == lo_y) || (ry == hi_y);
            hit_c[i]  = hit_x && hit_y;
            edge_c[i] = hit_x && hit_y && (edge_x || edge_y);
        end
    end

    // Stage 1: register per-cell results with the pixel qualifier.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_s1  <= '0;
            edge_s1 <= '0;
            pv_s1   <= 1'b0;
        end else begin
            hit_s1  <= hit_c;
            edge_s1 <= edge_c;
            pv_s1   <= pix_valid;
        end
    end

    // Stage 2: reduce across cells and gate by front presence and blinking.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_shape <= 1'b0;
            is_edge  <= 1'b0;
        end else begin
            is_shape <= pv_s1 && front_valid && visible && (|hit_s1);
            is_edge  <= pv_s1 && front_valid && visible && (|edge_s1);
        end
    end

endmodule

// File: doc/shape_renderer.md
SHAPE_RENDERER -- requirements
Module: shape_renderer

Interface
REQ-001 SHALL have parameter CELL_PX, default 24, meaning cell edge length in pixels.
REQ-002 SHALL have parameter X_OFFSET, default 144, meaning playfield left edge in DrawX pixels.
REQ-003 SHALL have parameter Y_OFFSET, default 0, meaning playfield top edge in DrawY pixels.
REQ-004 SHALL have parameter NUM_CELLS, default 4, meaning cells per piece.
REQ-005 SHALL have parameters XW, default 4, and YW, default 5, meaning cell-coordinate widths.
REQ-006 SHALL have parameter COLOR_W, default 3, meaning piece colour index width.
REQ-007 SHALL have parameter BLINK_FRAMES, default 30, meaning frames per blink half-period.
REQ-008 SHALL have ports: Clk in 1, system clock; Reset_n in 1, asynchronous active-low reset.
REQ-009 SHALL have ports: load_valid in 1, offer new piece; load_ready out 1, piece accepted when both high.
REQ-010 SHALL have ports: load_x in NUM_CELLS*XW, cell i at bits [i*XW +: XW]; load_y in NUM_CELLS*YW, same packing.
REQ-011 SHALL have ports: load_color in COLOR_W, colour index; clear in 1, remove piece.
REQ-012 SHALL have ports: frame_start in 1, one-cycle pulse at frame start; blink_en in 1, enable blinking.
REQ-013 SHALL have ports: DrawX, DrawY in 10 each, current pixel; pix_valid in 1, pixel qualifier.
REQ-014 SHALL have ports: is_shape out 1, pixel inside a visible cell; is_edge out 1, pixel on a cell border; shape_color out COLOR_W, front colour.

Function
REQ-015 SHALL hold a pending buffer and a front buffer, each NUM_CELLS coordinate pairs plus colour.
REQ-016 SHALL run states IDLE (no piece), PENDING (pending full, front empty), ACTIVE (front valid, pending empty), ACTIVE_PEND (front valid, pending full).
REQ-017 SHALL drive load_ready = 1 exactly in IDLE and ACTIVE with clear low.
REQ-018 SHALL, on acceptance, capture load_x/load_y/load_color into pending: IDLE->PENDING, ACTIVE->ACTIVE_PEND.
REQ-019 SHALL, on frame_start, copy pending to front: PENDING->ACTIVE, ACTIVE_PEND->ACTIVE; the front never changes at any other time.
REQ-020 SHALL, for load and frame_start in the same cycle, accept the load into pending and not promote it until the next frame_start.
REQ-021 SHALL, on clear, empty both buffers and go to IDLE next cycle; clear beats load and frame_start.
REQ-022 SHALL compute rx = DrawX - X_OFFSET and ry = DrawY - Y_OFFSET; DrawX < X_OFFSET or DrawY < Y_OFFSET is never a hit (no wrap).
REQ-023 SHALL hit cell i when cx*CELL_PX <= rx <= (cx+1)*CELL_PX-1 and cy*CELL_PX <= ry <= (cy+1)*CELL_PX-1, using 10-bit or wider unsigned arithmetic.
REQ-024 SHALL set is_edge when the pixel hits a cell and rx or ry is on that cell's first or last pixel row or column.
REQ-025 SHALL pipeline in two registered stages: per-cell compare, then OR reduction and gating; DrawX/DrawY/pix_valid at cycle n appear on is_shape/is_edge at cycle n+2.
REQ-026 SHALL force is_shape and is_edge to 0 when pix_valid is low, the front is empty, or the piece is blanked.
REQ-027 SHALL, with blink_en high, count frame_start pulses from 0 to BLINK_FRAMES-1, toggle a visible flag at each wrap to 0, and blank while visible = 0.
REQ-028 SHALL, when blink_en is low, zero the counter and set visible = 1 on the next cycle.
REQ-029 SHALL drive shape_color from the front colour, and 0 when the front is empty.

Reset
REQ-030 SHALL, when Reset_n is low, asynchronously enter IDLE, clear both buffers, zero the blink counter, set visible = 1, and zero is_shape, is_edge, shape_color and pipeline registers.
REQ-031 SHALL drive load_ready = 1 in the first cycle after Reset_n rises.
REQ-032 SHALL, for reset mid-blink or mid-frame, discard all state without waiting for frame_start.

Verification
REQ-033 Load x0=2, y0=3, rest {0,0}, colour 5, then frame_start; drive DrawX=192, DrawY=72 -> two cycles later is_shape=1, is_edge=1, shape_color=5.
REQ-034 Same piece, DrawX=203, DrawY=83 -> is_shape=1, is_edge=0; DrawX=216, DrawY=83 -> is_shape=0.
REQ-035 DrawX=100, DrawY=10 with cell {0,0} loaded -> is_shape=0 (no wrap); DrawX=144, DrawY=0 -> is_shape=1.
REQ-036 Load piece B while A is active, with no frame_start -> load_ready=0 and output still shows A; after frame_start -> output shows B and load_ready=1.
REQ-037 blink_en=1, BLINK_FRAMES=2 -> hit pixel visible for 2 frames, blank for 2, visible again; clear mid-sequence -> IDLE, is_shape=0.
REQ-038 Reset_n pulsed low asynchronously in ACTIVE_PEND -> outputs 0 immediately, load_ready=1 after release.
